// File: rtl/fetch_pc_pkg.sv
// rtl/fetch_pc_pkg.sv - shared memory-map constants and helpers for the fetch stage
//
// Holds the text-segment bounds and exception vector used as parameter
// defaults by fetch_pc, the next-PC source encoding used by fetch_npc, and the
// fetch-address legality test used when FETCH_ADDR_CHECK_EN is defined.
package fetch_pc_pkg;

  localparam logic [31:0] TEXT_START_DEF   = 32'h0000_3000;
  localparam logic [31:0] TEXT_END_DEF     = 32'h0000_4FFC;
  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;

  // Source of the next fetch address, listed in priority order.
  typedef enum logic [2:0] {
    NPC_EXC      = 3'd0,
    NPC_ERET     = 3'd1,
    NPC_STALL    = 3'd2,
    NPC_REDIRECT = 3'd3,
    NPC_SEQ      = 3'd4
  } npc_sel_e;

  // True when a fetch address is misaligned or lies outside [lo, hi].
  function automatic logic addr_bad(input logic [31:0] addr,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
  endfunction

endpackage

// File: rtl/fetch_npc.sv
// rtl/fetch_npc.sv - combinational next-PC priority mux
//
// Ports:
//   stall, redirect, exc_take, eret  - control qualifiers for this cycle
//   redirect_pc                      - branch/jump target
//   epc                              - ERET return address
//   pc_f                             - current F-stage PC
//   next_pc                          - selected next fetch address
module fetch_npc
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF
) (
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc_take,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic [31:0] pc_f,
  output logic [31:0] next_pc
);

  npc_sel_e sel;

  // Exceptions and ERET beat a stall; a redirect seen during a stall is
  // dropped because the D stage presents it again once the stall releases.
  always_comb begin
    sel = NPC_SEQ;
    if (exc_take)      sel = NPC_EXC;
    else if (eret)     sel = NPC_ERET;
    else if (stall)    sel = NPC_STALL;
    else if (redirect) sel = NPC_REDIRECT;
  end

  always_comb begin
    next_pc = pc_f + 32'd4;
    case (sel)
      NPC_EXC:      next_pc = HANDLER_ADDR;
      NPC_ERET:     next_pc = epc;
      NPC_STALL:    next_pc = pc_f;
      NPC_REDIRECT: next_pc = redirect_pc;
      default:      next_pc = pc_f + 32'd4;
    endcase
  end

endmodule

// File: rtl/fetch_pc.sv
// rtl/fetch_pc.sv - F-stage program counter and fetch control
//
// Optional feature macro: FETCH_ADDR_CHECK_EN (registered address-error flag).
//
// Ports:
//   Clk, Reset_n           - clock, asynchronous active-low reset
//   Stall                  - hold PC and re-fetch the current word
//   Redirect, RedirectPC   - taken branch/jump and its target
//   ExcTake                - exception accepted, fetch from HANDLER_ADDR
//   Eret, EPC              - ERET committed, fetch from EPC
//   IM_Addr                - next fetch address to the synchronous BRAM
//   PC_F, PC4_F            - address of the word on the BRAM output, and +4
//   Valid_F                - BRAM output holds a real fetched word
//   ExcAdEL_F              - PC_F misaligned or outside the text segment
module fetch_pc
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] TEXT_START   = TEXT_START_DEF,
  parameter logic [31:0] TEXT_END     = TEXT_END_DEF,
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        ExcTake,
  input  logic        Eret,
  input  logic [31:0] EPC,
  output logic [31:0] IM_Addr,
  output logic [31:0] PC_F,
  output logic [31:0] PC4_F,
  output logic        Valid_F,
  output logic        ExcAdEL_F
);

  if (TEXT_END < TEXT_START) begin : g_bad_text_range
    $error("fetch_pc: TEXT_END below TEXT_START");
  end

  logic [31:0] next_pc;
  logic [31:0] pc_q;
  logic        valid_q;

  fetch_npc #(
    .HANDLER_ADDR(HANDLER_ADDR)
  ) u_npc (
    .stall      (Stall),
    .redirect   (Redirect),
    .redirect_pc(RedirectPC),
    .exc_take   (ExcTake),
    .eret       (Eret),
    .epc        (EPC),
    .pc_f       (pc_q),
    .next_pc    (next_pc)
  );

  // The BRAM registers IM_Addr on the same edge that loads PC_F, so its
  // output word always belongs to PC_F. During reset the memory is pointed
  // at the reset PC rather than whatever the mux happens to produce.
  assign IM_Addr = Reset_n ? next_pc : TEXT_START;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q    <= TEXT_START;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= next_pc;
      valid_q <= 1'b1;
    end
  end

  assign PC_F    = pc_q;
  assign PC4_F   = pc_q + 32'd4;
  assign Valid_F = valid_q;

`ifdef FETCH_ADDR_CHECK_EN
  // Checked on next_pc so the flag is registered alongside PC_F. A flagged
  // address is still fetched; later stages squash the word.
  logic adel_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) adel_q <= 1'b0;
    else          adel_q <= addr_bad(next_pc, TEXT_START, TEXT_END);
  end

  assign ExcAdEL_F = adel_q;
`else
  assign ExcAdEL_F = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// tb/tb_fetch_pc.sv - self-checking bench for fetch_pc
module tb_fetch_pc;

  localparam logic [31:0] TS = 32'h0000_3000;
  localparam logic [31:0] TE = 32'h0000_4FFC;
  localparam logic [31:0] HA = 32'h0000_4180;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Stall, Redirect, ExcTake, Eret;
  logic [31:0] RedirectPC, EPC;
  logic [31:0] IM_Addr, PC_F, PC4_F;
  logic        Valid_F, ExcAdEL_F;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the fetch stage should be showing right now.
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_adel;

  always #5 Clk = ~Clk;

  fetch_pc dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Stall     (Stall),
    .Redirect  (Redirect),
    .RedirectPC(RedirectPC),
    .ExcTake   (ExcTake),
    .Eret      (Eret),
    .EPC       (EPC),
    .IM_Addr   (IM_Addr),
    .PC_F      (PC_F),
    .PC4_F     (PC4_F),
    .Valid_F   (Valid_F),
    .ExcAdEL_F (ExcAdEL_F)
  );

  function automatic logic [31:0] ref_next(input logic [31:0] pc,
                                           input logic s, input logic r,
                                           input logic [31:0] rpc,
                                           input logic e, input logic er,
                                           input logic [31:0] epc_v);
    if (e)  return HA;
    if (er) return epc_v;
    if (s)  return pc;
    if (r)  return rpc;
    return pc + 32'd4;
  endfunction

  function automatic logic ref_flag(input logic [31:0] a);
`ifdef FETCH_ADDR_CHECK_EN
    return ((a % 4) != 0) || (a < TS) || (a > TE);
`else
    return (a != a);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] exp_im;
    exp_im = Reset_n ? ref_next(m_pc, Stall, Redirect, RedirectPC, ExcTake, Eret, EPC) : TS;
    check({tag, ".IM_Addr"},   IM_Addr,            exp_im);
    check({tag, ".PC_F"},      PC_F,               m_pc);
    check({tag, ".PC4_F"},     PC4_F,              m_pc + 32'd4);
    check({tag, ".Valid_F"},   {31'b0, Valid_F},   {31'b0, m_valid});
    check({tag, ".ExcAdEL_F"}, {31'b0, ExcAdEL_F}, {31'b0, m_adel});
  endtask

  // Entered just after a falling edge: drive, check, cross the rising edge.
  task automatic step(input string tag, input logic s, input logic r,
                      input logic [31:0] rpc, input logic e, input logic er,
                      input logic [31:0] epc_v);
    logic [31:0] nx;
    Stall = s; Redirect = r; RedirectPC = rpc; ExcTake = e; Eret = er; EPC = epc_v;
    #1;
    compare_all(tag);
    nx = ref_next(m_pc, s, r, rpc, e, er, epc_v);
    @(posedge Clk);
    m_pc    = nx;
    m_valid = 1'b1;
    m_adel  = ref_flag(nx);
    @(negedge Clk);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic redir(input string tag, input logic [31:0] tgt);
    step(tag, 1'b0, 1'b1, tgt, 1'b0, 1'b0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0, 1:    return TS + 32'($urandom_range(0, (TE - TS) / 4)) * 32'd4;
      2:       return TS + 32'($urandom_range(0, (TE - TS)));
      3:       return $urandom();
      default: return ($urandom_range(0, 1) == 0) ? TE : TS - 32'd4;
    endcase
  endfunction

  initial begin
    Reset_n = 1'b0;
    Stall = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0;
    ExcTake = 1'b0; Eret = 1'b0; EPC = 32'h0;
    m_pc = TS; m_valid = 1'b0; m_adel = 1'b0;

    // Reset state, held across a couple of clock edges.
    @(negedge Clk); #1;
    compare_all("reset0");
    @(negedge Clk); #1;
    compare_all("reset1");
    @(negedge Clk);
    Reset_n = 1'b1;

    // Sequential fetch after release.
    idle("seq0");
    idle("seq1");
    idle("seq2");
    check("seq.pc_300c", PC_F, 32'h0000_300C);
    idle("seq3");
    check("seq.pc_3010", PC_F, 32'h0000_3010);

    // Three-cycle stall at 0x3010.
    step("stall0", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step("stall1", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step("stall2", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("stall.held", PC_F, 32'h0000_3010);
    idle("stall_rel");
    check("stall.pc_3014", PC_F, 32'h0000_3014);

    // Redirect, then the same redirect under a stall.
    redir("redir", 32'h0000_3200);
    check("redir.pc_3200", PC_F, 32'h0000_3200);
    step("redir_stall", 1'b1, 1'b1, 32'h0000_3400, 1'b0, 1'b0, 32'h0);
    check("redir_stall.pc", PC_F, 32'h0000_3200);

    // Exception beats everything, then ERET.
    step("exc_all", 1'b1, 1'b1, 32'h0000_3400, 1'b1, 1'b1, 32'h0000_3050);
    check("exc.pc_handler", PC_F, 32'h0000_4180);
    step("eret", 1'b1, 1'b1, 32'h0000_3400, 1'b0, 1'b1, 32'h0000_3024);
    check("eret.pc_3024", PC_F, 32'h0000_3024);

    // Address-error cases and segment boundaries.
    redir("adel_misalign", 32'h0000_3202);
    check("adel.misalign", {31'b0, ExcAdEL_F}, {31'b0, ref_flag(32'h0000_3202)});
    redir("adel_above", 32'h0000_5000);
    check("adel.above", {31'b0, ExcAdEL_F}, {31'b0, ref_flag(32'h0000_5000)});
    redir("adel_ok", 32'h0000_3200);
    check("adel.ok", {31'b0, ExcAdEL_F}, 32'h0);
    redir("edge_end", TE);
    idle("edge_past_end");
    redir("edge_below", TS - 32'd4);
    redir("wrap_top", 32'hFFFF_FFFC);
    idle("wrap");
    check("wrap.pc_zero", PC_F, 32'h0);

    // Asynchronous reset in the middle of a stream.
    redir("pre_rst", 32'h0000_30FC);
    idle("pre_rst2");
    check("pre_rst.pc_3100", PC_F, 32'h0000_3100);
    Redirect = 1'b1; RedirectPC = 32'h0000_3800;
    Reset_n = 1'b0;
    #1;
    m_pc = TS; m_valid = 1'b0; m_adel = 1'b0;
    compare_all("async_rst");
    @(posedge Clk);
    @(negedge Clk); #1;
    compare_all("rst_hold");
    @(negedge Clk);
    Reset_n = 1'b1;
    idle("restart0");
    idle("restart1");
    check("restart.pc_3008", PC_F, 32'h0000_3008);

    // Random control traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0,
           rand_addr(),
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 15) == 0,
           rand_addr());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
